// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared types, LFSR constants and 7-segment glyphs for the dice bank
package dice_pkg;

  typedef enum logic [1:0] {
    DIE_IDLE    = 2'd0,
    DIE_ROLLING = 2'd1,
    DIE_HELD    = 2'd2
  } die_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/dice_channel.sv
// rtl/dice_channel.sv - one die: button synchroniser, debouncer, roll FSM, running counter, held value
module dice_channel
  import dice_pkg::*;
#(
  parameter int FACES        = 6,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int ROLL_CYC     = 200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn,
  input  logic       i_press_all,
  input  logic       i_lfsr_bit,
  output die_state_t o_state,
  output logic [3:0] o_run,
  output logic [3:0] o_val,
  output logic       o_rolled
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int RW  = (ROLL_CYC > 1) ? $clog2(ROLL_CYC) : 1;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_deb;
  logic           r_deb_d;
  logic [DBW-1:0] r_deb_cnt;
  die_state_t     r_state;
  logic [RW-1:0]  r_timer;
  logic [3:0]     r_run;
  logic [3:0]     r_val;
  logic           r_rolled;
  logic           w_press;
  logic           w_go;

  assign w_press = r_deb & ~r_deb_d;
  assign w_go    = w_press | i_press_all;

  // Debounced level flips only after DEBOUNCE_CYC consecutive samples disagree with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_deb_d <= r_deb;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= DIE_IDLE;
      r_timer  <= '0;
      r_run    <= 4'd1;
      r_val    <= 4'd0;
      r_rolled <= 1'b0;
    end else begin
      case (r_state)
        DIE_IDLE, DIE_HELD: begin
          if (w_go) begin
            r_state <= DIE_ROLLING;
            r_timer <= RW'(ROLL_CYC - 1);
          end
        end
        DIE_ROLLING: begin
          if (r_timer == '0) begin
            r_val    <= r_run;
            r_rolled <= 1'b1;
            r_state  <= DIE_HELD;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: r_state <= DIE_IDLE;
      endcase
      if (i_lfsr_bit) begin
        r_run <= (r_run == 4'(FACES)) ? 4'd1 : r_run + 4'd1;
      end
    end
  end

  assign o_state  = r_state;
  assign o_run    = r_run;
  assign o_val    = r_val;
  assign o_rolled = r_rolled;

endmodule

// File: rtl/dice_bank_mux.sv
// rtl/dice_bank_mux.sv - N-die dice bank with roll-all, shared LFSR and multiplexed 7-segment display
// Optional DOUBLES_BLINK_EN: blanks the display in the upper half of an 18-bit blink period while all dice match.
module dice_bank_mux
  import dice_pkg::*;
#(
  parameter int N_DICE       = 2,
  parameter int FACES        = 6,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int ROLL_CYC     = 200000,
  parameter int SCAN_CYC     = 5000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_DICE-1:0]     roll_btn,
  input  logic                  roll_all,
  input  logic                  common_cathode,
  output logic [6:0]            seg,
  output logic [N_DICE-1:0]     dig_sel,
  output logic [N_DICE-1:0]     rolled,
  output logic [4*N_DICE-1:0]   dice_val,
  output logic                  all_equal
);

  localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SW  = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  logic           r_all_s1;
  logic           r_all_s2;
  logic           r_all_deb;
  logic           r_all_deb_d;
  logic [DBW-1:0] r_all_cnt;
  logic [15:0]    r_lfsr;
  logic [SW-1:0]  r_scan;
  logic [N_DICE-1:0] r_dig;
  logic [6:0]     r_seg;
  logic           r_all_eq;
  logic           w_press_all;
  logic [6:0]     w_glyph;
  logic [6:0]     w_seg_ah;
  logic           w_blank;
  logic           w_all_eq;
  die_state_t     w_state [N_DICE];
  logic [3:0]     w_run   [N_DICE];
  logic [3:0]     w_val   [N_DICE];

  assign w_press_all = r_all_deb & ~r_all_deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_all_s1    <= 1'b0;
      r_all_s2    <= 1'b0;
      r_all_deb   <= 1'b0;
      r_all_deb_d <= 1'b0;
      r_all_cnt   <= '0;
    end else begin
      r_all_s1    <= roll_all;
      r_all_s2    <= r_all_s1;
      r_all_deb_d <= r_all_deb;
      if (r_all_s2 == r_all_deb) begin
        r_all_cnt <= '0;
      end else if (r_all_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
        r_all_deb <= r_all_s2;
        r_all_cnt <= '0;
      end else begin
        r_all_cnt <= r_all_cnt + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_DICE; g++) begin : g_die
    dice_channel #(
      .FACES        (FACES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ROLL_CYC     (ROLL_CYC)
    ) u_die (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_btn       (roll_btn[g]),
      .i_press_all (w_press_all),
      .i_lfsr_bit  (r_lfsr[g % 16]),
      .o_state     (w_state[g]),
      .o_run       (w_run[g]),
      .o_val       (w_val[g]),
      .o_rolled    (rolled[g])
    );
    assign dice_val[4*g +: 4] = w_val[g];
  end

  always_comb begin
    w_glyph = SEG_DASH;
    for (int k = 0; k < N_DICE; k++) begin
      if (r_dig[k]) begin
        if (w_state[k] == DIE_ROLLING)   w_glyph = seg_glyph(w_run[k]);
        else if (w_state[k] == DIE_HELD) w_glyph = seg_glyph(w_val[k]);
      end
    end
  end

  // A single die has nothing to compare against, so "all equal" degenerates to "has a result".
  always_comb begin
    w_all_eq = 1'b1;
    for (int k = 0; k < N_DICE; k++) begin
      if (w_state[k] != DIE_HELD || w_val[k] != w_val[0]) w_all_eq = 1'b0;
    end
    if (N_DICE == 1) w_all_eq = rolled[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr   <= LFSR_SEED;
      r_scan   <= '0;
      r_dig    <= N_DICE'(1);
      r_seg    <= SEG_DASH;
      r_all_eq <= 1'b0;
    end else begin
      r_lfsr   <= r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);
      r_seg    <= w_glyph;
      r_all_eq <= w_all_eq;
      if (r_scan == SW'(SCAN_CYC - 1)) begin
        r_scan <= '0;
        r_dig  <= (r_dig << 1) | (r_dig >> (N_DICE - 1));
      end else begin
        r_scan <= r_scan + 1'b1;
      end
    end
  end

`ifdef DOUBLES_BLINK_EN
  logic [17:0] r_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_blink <= '0;
    else if (!r_all_eq) r_blink <= '0;
    else                r_blink <= r_blink + 18'd1;
  end

  assign w_blank = r_all_eq & r_blink[17];
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_ah  = w_blank ? SEG_BLANK : r_seg;
  assign seg       = common_cathode ? w_seg_ah : ~w_seg_ah;
  assign dig_sel   = r_dig;
  assign all_equal = r_all_eq;

endmodule

// File: tb/tb_dice_bank_mux.sv
// tb/tb_dice_bank_mux.sv - randomized self-checking bench for dice_bank_mux against a cycle reference model
module tb_dice_bank_mux;

  localparam int N = 3, F = 6, D = 4, R = 8, S = 2;

  logic        clk, rst_n, roll_all, common_cathode, all_equal;
  logic [2:0]  roll_btn, dig_sel, rolled;
  logic [6:0]  seg;
  logic [11:0] dice_val;
  int          n_chk, n_pass;

  dice_bank_mux #(.N_DICE(N), .FACES(F), .DEBOUNCE_CYC(D), .ROLL_CYC(R), .SCAN_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .roll_btn(roll_btn), .roll_all(roll_all),
    .common_cathode(common_cathode), .seg(seg), .dig_sel(dig_sel), .rolled(rolled),
    .dice_val(dice_val), .all_equal(all_equal));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: die state 0=idle 1=rolling 2=held; inputs 0..2 are dice, 3 is roll_all.
  int          e_n, m_dig, m_scan;
  int          m_st[N], m_end[N], m_run[N], m_val[N];
  bit          m_rolled[N], m_deb[4], m_rose[4], m_press[4], m_aeq, t_aeq;
  logic [15:0] m_lfsr, m_hist[4], w_win;
  logic [17:0] m_blink;
  logic [6:0]  m_seg_ah;
  logic [3:0]  m_raw;

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic model_reset();
    e_n = 0; m_dig = 0; m_scan = 0; m_lfsr = 16'hACE1; m_seg_ah = 7'h40; m_aeq = 0; m_blink = '0;
    for (int k = 0; k < 4; k++) begin m_hist[k] = '0; m_deb[k] = 0; m_rose[k] = 0; end
    for (int i = 0; i < N; i++) begin m_st[i] = 0; m_end[i] = 0; m_run[i] = 1; m_val[i] = 0; m_rolled[i] = 0; end
  endtask

  task automatic model_edge();
    m_raw = {roll_all, roll_btn};
    e_n++;
    m_seg_ah = (m_st[m_dig] == 1) ? glyph(m_run[m_dig]) : (m_st[m_dig] == 2) ? glyph(m_val[m_dig]) : 7'h40;
    m_blink = m_aeq ? m_blink + 18'd1 : 18'd0;
    t_aeq = 1;
    for (int i = 0; i < N; i++) if (m_st[i] != 2 || m_val[i] != m_val[0]) t_aeq = 0;
    m_aeq = t_aeq;
    // The debouncer sees each raw sample two edges late and needs D identical new samples.
    for (int k = 0; k < 4; k++) begin
      m_press[k] = m_rose[k];
      m_rose[k]  = 0;
      w_win = (m_hist[k] >> 1) & 16'((1 << D) - 1);
      if (m_deb[k] ? (w_win == 16'd0) : (w_win == 16'((1 << D) - 1))) begin
        m_deb[k]  = !m_deb[k];
        m_rose[k] = m_deb[k];
      end
      m_hist[k] = {m_hist[k][14:0], m_raw[k]};
    end
    for (int i = 0; i < N; i++) begin
      if (m_st[i] == 1) begin
        if (e_n == m_end[i]) begin m_val[i] = m_run[i]; m_st[i] = 2; m_rolled[i] = 1; end
      end else if (m_press[i] || m_press[3]) begin
        m_st[i] = 1; m_end[i] = e_n + R;
      end
    end
    for (int i = 0; i < N; i++) if (m_lfsr[i % 16]) m_run[i] = (m_run[i] == F) ? 1 : m_run[i] + 1;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    if (m_scan == S - 1) begin m_scan = 0; m_dig = (m_dig + 1) % N; end else m_scan++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset(); else model_edge();
    end
  end

  function automatic logic [6:0] e_seg();
    logic [6:0] s = m_seg_ah;
`ifdef DOUBLES_BLINK_EN
    if (m_aeq && m_blink[17]) s = 7'h00;
`endif
    return common_cathode ? s : ~s;
  endfunction

  function automatic logic [2:0] e_dig();
    return 3'(1 << m_dig);
  endfunction

  function automatic logic [11:0] e_val();
    logic [11:0] v = '0;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'(m_val[i]);
    return v;
  endfunction

  function automatic logic [2:0] e_rolled();
    logic [2:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_rolled[i];
    return r;
  endfunction

  task automatic test_reset();
    logic [2:0] exp_dig;
    rst_n = 0; roll_btn = '0; roll_all = 0; common_cathode = 1;
    repeat (3) @(negedge clk);
    n_chk++; if (rolled !== 3'b000) $display("FAIL reset_rolled: got %b exp 000", rolled); else n_pass++;
    n_chk++; if (dice_val !== 12'h000) $display("FAIL reset_val: got %h exp 000", dice_val); else n_pass++;
    n_chk++; if (dig_sel !== 3'b001) $display("FAIL reset_dig: got %b exp 001", dig_sel); else n_pass++;
    n_chk++; if (all_equal !== 1'b0) $display("FAIL reset_aeq: got %b exp 0", all_equal); else n_pass++;
    n_chk++; if (seg !== 7'h40) $display("FAIL reset_seg: got %h exp 40", seg); else n_pass++;
    rst_n = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_dig = 3'b001 << ((k / 2) % 3);
      n_chk++; if (dig_sel !== exp_dig) $display("FAIL scan_dig: got %b exp %b", dig_sel, exp_dig); else n_pass++;
      n_chk++; if (seg !== 7'h40) $display("FAIL idle_dash: got %h exp 40", seg); else n_pass++;
      n_chk++; if (rolled !== 3'b000) $display("FAIL idle_rolled: got %b exp 000", rolled); else n_pass++;
    end
  endtask

  task automatic test_glitch();
    roll_btn = 3'b010;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (c == 2) roll_btn = '0;
      n_chk++; if (rolled !== 3'b000) $display("FAIL glitch_rolled: got %b exp 000", rolled); else n_pass++;
      n_chk++; if (seg !== 7'h40) $display("FAIL glitch_seg: got %h exp 40", seg); else n_pass++;
    end
  endtask

  task automatic test_single_roll();
    logic [2:0] exp_r;
    roll_btn = 3'b010;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c == 9) roll_btn = '0;
      exp_r = (c >= 2 + D + R) ? 3'b010 : 3'b000;
      n_chk++; if (rolled !== exp_r) $display("FAIL single_rolled c=%0d: got %b exp %b", c, rolled, exp_r); else n_pass++;
      n_chk++; if (dice_val !== e_val()) $display("FAIL single_val c=%0d: got %h exp %h", c, dice_val, e_val()); else n_pass++;
      n_chk++; if (seg !== e_seg()) $display("FAIL single_seg c=%0d: got %h exp %h", c, seg, e_seg()); else n_pass++;
      if (c == 2 + D + R) begin
        n_chk++;
        if (dice_val[7:4] < 4'd1 || dice_val[7:4] > 4'd6) $display("FAIL single_range: got %0d exp 1..6", dice_val[7:4]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_press_during_roll();
    logic [2:0] exp_r;
    roll_btn = 3'b010;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      if (c == 1) roll_all = 1;
      if (c == 6) roll_btn = '0;
      if (c == 7) roll_all = 0;
      exp_r = (c >= 16) ? 3'b111 : 3'b010;
      n_chk++; if (rolled !== exp_r) $display("FAIL reroll_rolled c=%0d: got %b exp %b", c, rolled, exp_r); else n_pass++;
      n_chk++; if (dice_val !== e_val()) $display("FAIL reroll_val c=%0d: got %h exp %h", c, dice_val, e_val()); else n_pass++;
      n_chk++; if (seg !== e_seg()) $display("FAIL reroll_seg c=%0d: got %h exp %h", c, seg, e_seg()); else n_pass++;
    end
  endtask

  task automatic test_roll_all_equal();
    bit found = 0;
    for (int a = 0; a < 300 && !found; a++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      roll_all = 1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 5) roll_all = 0;
        n_chk++; if (all_equal !== m_aeq) $display("FAIL aeq: got %b exp %b", all_equal, m_aeq); else n_pass++;
        n_chk++; if (dice_val !== e_val()) $display("FAIL aeq_val: got %h exp %h", dice_val, e_val()); else n_pass++;
        n_chk++; if (rolled !== e_rolled()) $display("FAIL aeq_rolled: got %b exp %b", rolled, e_rolled()); else n_pass++;
      end
      if (m_aeq) begin
        found = 1;
        n_chk++; if (all_equal !== 1'b1) $display("FAIL aeq_doubles: got %b exp 1", all_equal); else n_pass++;
      end
    end
    n_chk++; if (!found) $display("FAIL aeq_search: got no equal roll exp one within 300 tries"); else n_pass++;
  endtask

  task automatic test_polarity();
    roll_all = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 6) roll_all = 0;
      common_cathode = 1'($urandom_range(0, 1));
      #1;
      n_chk++; if (seg !== e_seg()) $display("FAIL polarity cc=%b: got %h exp %h", common_cathode, seg, e_seg()); else n_pass++;
    end
    common_cathode = 1;
  endtask

  task automatic test_random();
    int len, gap;
    for (int it = 0; it < 15; it++) begin
      roll_btn = 3'($urandom_range(1, 7));
      len = $urandom_range(1, 10);
      gap = $urandom_range(0, 12);
      for (int c = 0; c < len + gap; c++) begin
        @(negedge clk);
        if (c == len - 1) roll_btn = '0;
        n_chk++; if (seg !== e_seg()) $display("FAIL rnd_seg: got %h exp %h", seg, e_seg()); else n_pass++;
        n_chk++; if (dig_sel !== e_dig()) $display("FAIL rnd_dig: got %b exp %b", dig_sel, e_dig()); else n_pass++;
        n_chk++; if (rolled !== e_rolled()) $display("FAIL rnd_rolled: got %b exp %b", rolled, e_rolled()); else n_pass++;
        n_chk++; if (dice_val !== e_val()) $display("FAIL rnd_val: got %h exp %h", dice_val, e_val()); else n_pass++;
        n_chk++; if (all_equal !== m_aeq) $display("FAIL rnd_aeq: got %b exp %b", all_equal, m_aeq); else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_roll();
    repeat (20) @(negedge clk);
    roll_all = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 5) roll_all = 0;
    end
    #2 rst_n = 0;
    #1;
    n_chk++; if (rolled !== 3'b000) $display("FAIL midrst_rolled: got %b exp 000", rolled); else n_pass++;
    n_chk++; if (dice_val !== 12'h000) $display("FAIL midrst_val: got %h exp 000", dice_val); else n_pass++;
    n_chk++; if (dig_sel !== 3'b001) $display("FAIL midrst_dig: got %b exp 001", dig_sel); else n_pass++;
    n_chk++; if (all_equal !== 1'b0) $display("FAIL midrst_aeq: got %b exp 0", all_equal); else n_pass++;
    @(negedge clk);
    rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++; if (dig_sel !== e_dig()) $display("FAIL post_rst_dig: got %b exp %b", dig_sel, e_dig()); else n_pass++;
      n_chk++; if (seg !== 7'h40) $display("FAIL post_rst_seg: got %h exp 40", seg); else n_pass++;
      n_chk++; if (rolled !== 3'b000) $display("FAIL post_rst_rolled: got %b exp 000", rolled); else n_pass++;
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 0; roll_btn = '0; roll_all = 0; common_cathode = 1;
    test_reset();
    test_glitch();
    test_single_roll();
    test_press_during_roll();
    test_roll_all_equal();
    test_polarity();
    test_random();
    test_reset_mid_roll();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
